test_sequencer: RTL and testbench
=================================

# test_sequencer

Runs the board self-tests (SD, flash, SDRAM) one at a time so they never contend for the board buses, and records a verdict for each. A test run starts on a one-cycle `start` pulse, normally the debounced edge of BTN_USER. For each enabled test the block pulses `*_init`, follows the test engine's `*_progress` handshake, latches its `*_result`, and guards each test with a timeout. It sits between the test engines and the `updater` text overlay, which displays `status` and `done`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 7_000_000: per-test limit in clk7 cycles (1 s at 7 MHz); must be ≥ 2.
- `TO_W`, default 24: timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports (clock and reset first):
- `clk7` in 1: system clock. Everything is sampled on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `start` in 1: one-cycle request to begin a run. Honoured only in IDLE or DONE.
- `test_mask` in 3: enable bits `{sdram, flash, sd}`. Sampled in the same cycle `start` is accepted.
- `sdtest_progress`, `flashtest_progress`, `sdramtest_progress` in 1 each: high while that test engine is running.
- `sdtest_result`, `flashtest_result`, `sdramtest_result` in 1 each: 1 = pass. Valid in the cycle the matching progress falls.
- `sdtest_init`, `flashtest_init`, `sdramtest_init` out 1 each: one-cycle registered start pulse to the test engine.
- `busy` out 1: a run is in progress.
- `done` out 1: the run has finished. Held until the next accepted `start` or `rst`.
- `cur_test` out 2: test currently running, 0 = sd, 1 = flash, 2 = sdram, 3 = none.
- `status` out 6: per-test verdict `{sdram[5:4], flash[3:2], sd[1:0]}`. Codes: 00 not run, 01 pass, 10 fail, 11 timeout.

## Operation
- States: IDLE, INIT, WAIT_ACK, WAIT_DONE, NEXT, DONE.
- IDLE / DONE, on `start`:
  - Latch `test_mask` and clear `status` to 0.
  - Set the test index to the lowest enabled test and go to INIT.
  - If the mask is 000, go straight to DONE.
- INIT: assert exactly one `*_init` for the current test, clear the timeout counter, go to WAIT_ACK.
- WAIT_ACK: wait for the current `*_progress` to go high, then go to WAIT_DONE.
- WAIT_DONE: when the current `*_progress` is sampled low:
  - Write 01 to the test's `status` field if `*_result` = 1, otherwise 10.
  - Go to NEXT.
- Timeout:
  - The counter increments every cycle in WAIT_ACK and WAIT_DONE.
  - If it reaches TIMEOUT_CYCLES−1 and the test has not completed in that cycle, write 11 to the test's `status` field and go to NEXT.
  - If completion and expiry happen in the same cycle, the completion verdict wins.
- NEXT (one cycle): advance to the next enabled test in the order sd, flash, sdram and go to INIT. If there is none, go to DONE.
- Disabled tests keep status 00 and never receive an init pulse.
- `start` outside IDLE/DONE is ignored; it is neither queued nor does it restart the run.
- Progress inputs of tests that are not current are ignored.
- `rst` at any time:
  - State goes to IDLE, `status` = 0, `done` = 0, `busy` = 0, `cur_test` = 3, all init outputs 0.
  - A pending init pulse is dropped.

## Timing
- All outputs are registered.
- Reset values: `*_init` = 0, `busy` = 0, `done` = 0, `cur_test` = 3, `status` = 000000.
- `start` high in cycle N (state IDLE): `busy` = 1, `status` = 0 and the first init pulse are all visible in cycle N+1.
- `*_init` is high for exactly 1 cycle per test.
- `cur_test` is valid from the init cycle through the NEXT cycle of that test.
- The earliest progress rise that counts is in the cycle after the init pulse.
- Progress low sampled in cycle M (WAIT_DONE): the verdict appears in `status` in cycle M+1 (NEXT).
  - If another test is enabled, its init pulse comes in cycle M+2.
  - Otherwise `done` = 1, `busy` = 0 and `cur_test` = 3 in cycle M+2.
- Timeout verdict: TIMEOUT_CYCLES cycles after the cycle following the init pulse.
- Minimum per-test overhead: 1 init cycle + 1 NEXT cycle.

## Test plan
- TIMEOUT_CYCLES = 100, mask 111, all engines raise progress 2 cycles after init, drop it 10 cycles later with result = 1 → three init pulses in order sd, flash, sdram; `status` = 010101; `done` = 1.
- Same run, but the flash engine returns result = 0 → `status` = 011001.
- Mask 111, the SDRAM engine never raises progress → sdram init pulse, then its status becomes 11 exactly 100 cycles after the cycle following that pulse; `status` = 110101; `done` = 1.
- Mask 010, plus a second `start` pulsed mid-run → only `flashtest_init` pulses; the extra `start` has no effect; `status` = 000100.
- Flash engine drops progress in the same cycle its counter reaches 99 → flash status is 01, not 11.
- `rst` asserted during the WAIT_DONE of the flash test, then `start` with mask 001 → after reset all outputs are at their reset values; the new run pulses only `sdtest_init` and ends with `status` = 000001.

Source files
------------

// File: rtl/test_sequencer.sv
// test_sequencer: runs enabled board self-tests one at a time and records per-test verdicts
module test_sequencer #(
  parameter int TIMEOUT_CYCLES = 7_000_000,
  parameter int TO_W = 24
) (
  input  logic       clk7,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] test_mask,
  input  logic       sdtest_progress,
  input  logic       flashtest_progress,
  input  logic       sdramtest_progress,
  input  logic       sdtest_result,
  input  logic       flashtest_result,
  input  logic       sdramtest_result,
  output logic       sdtest_init,
  output logic       flashtest_init,
  output logic       sdramtest_init,
  output logic       busy,
  output logic       done,
  output logic [1:0] cur_test,
  output logic [5:0] status
);
  typedef enum logic [2:0] {IDLE, INIT, WAIT_ACK, WAIT_DONE, NEXT, DONE} state_t;
  state_t state, state_n;
  logic [2:0] mask, mask_n, above;
  logic [1:0] idx, idx_n, code;
  logic [3:0] prog_v, res_v;
  logic [TO_W-1:0] cnt;
  logic [5:0] status_n;
  logic prog, res, expired, wr, clear, run_n;
  function automatic logic [1:0] lowest(input logic [2:0] m);
    return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
  endfunction
  assign prog_v = {1'b0, sdramtest_progress, flashtest_progress, sdtest_progress};
  assign res_v = {1'b0, sdramtest_result, flashtest_result, sdtest_result};
  assign prog = prog_v[idx];
  assign res = res_v[idx];
  assign expired = cnt == TO_W'(TIMEOUT_CYCLES - 1);
  assign above = idx == 2'd0 ? 3'b110 : idx == 2'd1 ? 3'b100 : 3'b000;
  assign clear = (state == IDLE || state == DONE) && start;
  assign run_n = state_n inside {INIT, WAIT_ACK, WAIT_DONE, NEXT};
  assign status_n = clear ? 6'd0 :
                    wr ? (status & ~(6'b000011 << {idx, 1'b0})) | (6'(code) << {idx, 1'b0}) : status;
  // next state, test index and verdict selection; completion beats expiry in the same cycle
  always_comb begin
    state_n = state;
    mask_n = mask;
    idx_n = idx;
    wr = 1'b0;
    code = 2'b00;
    case (state)
      IDLE, DONE: if (start) begin
        mask_n = test_mask;
        idx_n = lowest(test_mask);
        state_n = test_mask == 3'b000 ? DONE : INIT;
      end
      INIT: state_n = WAIT_ACK;
      WAIT_ACK: if (expired) begin
        wr = 1'b1;
        code = 2'b11;
        state_n = NEXT;
      end else if (prog) state_n = WAIT_DONE;
      WAIT_DONE: if (!prog || expired) begin
        wr = 1'b1;
        code = !prog ? (res ? 2'b01 : 2'b10) : 2'b11;
        state_n = NEXT;
      end
      NEXT: begin
        idx_n = lowest(mask & above);
        state_n = idx_n == 2'd3 ? DONE : INIT;
      end
      default: state_n = IDLE;
    endcase
  end
  // state, timeout counter and registered outputs derived from the next state
  always_ff @(posedge clk7) begin
    if (rst) begin
      state <= IDLE;
      mask <= 3'b000;
      idx <= 2'd3;
      cnt <= '0;
      status <= 6'd0;
      sdtest_init <= 1'b0;
      flashtest_init <= 1'b0;
      sdramtest_init <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      cur_test <= 2'd3;
    end else begin
      state <= state_n;
      mask <= mask_n;
      idx <= idx_n;
      cnt <= (state == WAIT_ACK || state == WAIT_DONE) ? cnt + 1'b1 : '0;
      status <= status_n;
      sdtest_init <= state_n == INIT && idx_n == 2'd0;
      flashtest_init <= state_n == INIT && idx_n == 2'd1;
      sdramtest_init <= state_n == INIT && idx_n == 2'd2;
      busy <= run_n;
      done <= state_n == DONE;
      cur_test <= run_n ? idx_n : 2'd3;
    end
  end
endmodule

// File: tb/tb_test_sequencer.sv
// tb_test_sequencer: timeline-model bench for test_sequencer with directed and random runs
module tb_test_sequencer;
  localparam int T = 100;
  logic clk7 = 1'b0, rst = 1'b1, start = 1'b0;
  logic [2:0] test_mask = 3'b000;
  logic sdtest_progress = 1'b0, flashtest_progress = 1'b0, sdramtest_progress = 1'b0;
  logic sdtest_result = 1'b0, flashtest_result = 1'b0, sdramtest_result = 1'b0;
  logic sdtest_init, flashtest_init, sdramtest_init, busy, done;
  logic [1:0] cur_test;
  logic [5:0] status;
  int checks = 0, errors = 0;
  int rr[3], ll[3];

  test_sequencer #(.TIMEOUT_CYCLES(T), .TO_W(8)) dut (
    .clk7(clk7), .rst(rst), .start(start), .test_mask(test_mask),
    .sdtest_progress(sdtest_progress), .flashtest_progress(flashtest_progress),
    .sdramtest_progress(sdramtest_progress), .sdtest_result(sdtest_result),
    .flashtest_result(flashtest_result), .sdramtest_result(sdramtest_result),
    .sdtest_init(sdtest_init), .flashtest_init(flashtest_init), .sdramtest_init(sdramtest_init),
    .busy(busy), .done(done), .cur_test(cur_test), .status(status)
  );

  always #5 clk7 = ~clk7;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_init"}, {5'd0, sdramtest_init, flashtest_init, sdtest_init}, 8'd0);
    chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
    chk({tag, "_done"}, {7'd0, done}, 8'd0);
    chk({tag, "_cur"}, {6'd0, cur_test}, 8'd3);
    chk({tag, "_status"}, {2'd0, status}, 8'd0);
  endtask

  // Each enabled test occupies init..next cycles; a test completes if its fall lands
  // no later than init+T, otherwise its verdict is a timeout at init+T+1.
  task automatic run(input logic [2:0] m, input logic [2:0] res, input int ms_in, input int rc);
    int ic[3], xc[3], v[3];
    int cyc, d, u, ms, ec;
    logic [2:0] p, ei;
    logic [5:0] es;
    cyc = 1;
    for (int k = 0; k < 3; k++) begin
      if (m[k]) begin
        ic[k] = cyc;
        if (rr[k] + ll[k] <= T) begin
          xc[k] = cyc + rr[k] + ll[k] + 1;
          v[k] = res[k] ? 1 : 2;
        end else begin
          xc[k] = cyc + T + 1;
          v[k] = 3;
        end
        cyc = xc[k] + 1;
      end else begin
        ic[k] = -1000;
        xc[k] = -1000;
        v[k] = 0;
      end
    end
    d = cyc;
    ms = ms_in < 0 ? (d > 1 ? int'($urandom_range(1, d - 1)) : 0) : ms_in;
    for (int t = 0; t <= d + 1; t++) begin
      start = t == 0 || (ms > 0 && t == ms);
      test_mask = t == 0 ? m : 3'($urandom);
      for (int k = 0; k < 3; k++)
        p[k] = m[k] && t >= ic[k] + rr[k] && t < ic[k] + rr[k] + ll[k];
      {sdramtest_progress, flashtest_progress, sdtest_progress} = p;
      {sdramtest_result, flashtest_result, sdtest_result} = res;
      rst = rc > 0 && t == rc;
      @(posedge clk7);
      #1;
      if (rst) begin
        rst = 1'b0;
        chk_reset("midrst");
        break;
      end
      u = t + 1;
      es = 6'd0;
      ec = 3;
      for (int k = 0; k < 3; k++) begin
        ei[k] = u == ic[k];
        if (m[k] && u >= xc[k]) es[2*k +: 2] = 2'(v[k]);
        if (u >= ic[k] && u <= xc[k]) ec = k;
      end
      chk($sformatf("init@%0d", u), {5'd0, sdramtest_init, flashtest_init, sdtest_init}, {5'd0, ei});
      chk($sformatf("busy@%0d", u), {7'd0, busy}, {7'd0, u < d});
      chk($sformatf("done@%0d", u), {7'd0, done}, {7'd0, u >= d});
      chk($sformatf("cur@%0d", u), {6'd0, cur_test}, 8'(ec));
      chk($sformatf("status@%0d", u), {2'd0, status}, {2'd0, es});
    end
    start = 1'b0;
    {sdramtest_progress, flashtest_progress, sdtest_progress} = 3'b000;
    repeat (2) @(posedge clk7);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk7);
    #1;
    chk_reset("reset");
    rst = 1'b0;
    rr = '{2, 2, 2};
    ll = '{10, 10, 10};
    run(3'b111, 3'b111, 0, 0);
    chk("all_pass", {2'd0, status}, 8'h15);
    run(3'b111, 3'b101, 0, 0);
    chk("flash_fail", {2'd0, status}, 8'h19);
    rr = '{2, 2, 1000};
    run(3'b111, 3'b111, 0, 0);
    chk("sdram_timeout", {2'd0, status}, 8'h35);
    rr = '{2, 2, 2};
    run(3'b010, 3'b111, 6, 0);
    chk("flash_only", {2'd0, status}, 8'h04);
    ll = '{10, 98, 10};
    run(3'b111, 3'b111, 0, 0);
    chk("edge_complete", {2'd0, status}, 8'h15);
    ll = '{10, 99, 10};
    run(3'b111, 3'b111, 0, 0);
    chk("edge_timeout", {2'd0, status}, 8'h1D);
    ll = '{10, 10, 10};
    run(3'b000, 3'b111, 0, 0);
    chk("empty_mask_done", {7'd0, done}, 8'd1);
    run(3'b111, 3'b111, 0, 20);
    run(3'b001, 3'b111, 0, 0);
    chk("after_reset", {2'd0, status}, 8'h01);
    for (int n = 0; n < 25; n++) begin
      for (int k = 0; k < 3; k++) begin
        rr[k] = $urandom_range(0, 7) == 0 ? 1000 : int'($urandom_range(1, 6));
        ll[k] = $urandom_range(0, 7) == 0 ? int'($urandom_range(90, 110)) : int'($urandom_range(1, 15));
      end
      run(3'($urandom), 3'($urandom), -1, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
